bus_interconnect_nxm: RTL
=========================

// Module: bus_interconnect_nxm
// PURPOSE
//  Parametrised N-master x M-slave system bus interconnect: round-robin arbiter plus grant-steered serial mux.
//  Successor to the fixed 2x3 interconnect, with an invalid-select error response, a transaction timeout watchdog and a turnaround cycle.
//  Sits between the master ports and the slave ports on sys_clk.
// PARAMETERS
//  NUM_MASTERS  2    number of master ports (2..8)
//  NUM_SLAVES   3    number of slave ports (1..8)
//  SEL_W        2    width of each master's slave-select field; sel >= NUM_SLAVES is invalid
//  TIMEOUT      256  max BUSY cycles before forced release (>=2)
// PORTS
//  sys_clk          in   1                 single clock
//  sys_rst          in   1                 asynchronous, active-low reset
//  m_request        in   NUM_MASTERS       bus request, one bit per master
//  m_slave_sel      in   NUM_MASTERS*SEL_W target slave index; master i uses bits [i*SEL_W +: SEL_W]
//  trans_done       in   1                 current transaction complete (1-cycle pulse)
//  m_grant          out  NUM_MASTERS       one-hot grant, registered
//  m_error          out  NUM_MASTERS       1-cycle pulse: invalid slave select refused
//  timeout_err      out  1                 1-cycle pulse: watchdog forced release
//  arbiter_busy     out  1                 state != IDLE
//  bus_busy         out  1                 state == BUSY
//  m_master_valid, m_master_ready, m_tx_address, m_tx_data, m_tx_burst_num, m_write_en, m_read_en  in   NUM_MASTERS  serial master->bus lines
//  m_rx_data, m_slave_valid, m_slave_ready                                                          out  NUM_MASTERS  serial bus->master lines
//  s_master_valid, s_master_ready, s_rx_address, s_rx_data, s_rx_burst_num, s_write_en, s_read_en   out  NUM_SLAVES   serial bus->slave lines
//  s_tx_data, s_slave_valid, s_slave_ready                                                          in   NUM_SLAVES   serial slave->bus lines
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=0, all grants/flags 0, every mux output 0; reset mid-transaction aborts immediately.
//  - FSM IDLE -> BUSY -> RELEASE -> IDLE.
//  - IDLE: if any m_request, choose winner by round-robin search from rr_ptr upward (wrapping at NUM_MASTERS-1 -> 0); latch win_idx, sel_idx.
//    - sel valid: next cycle state=BUSY, m_grant[win]=1 (grant latency 1 cycle from sampled request).
//    - sel invalid: m_error[win] pulses next cycle, state stays IDLE, rr_ptr = win+1 mod N, no grant.
//  - BUSY: watchdog counter clears on entry, increments each cycle. Exit to RELEASE on first of:
//    - trans_done = 1 (normal)
//    - m_request[win] = 0 (master abort)
//    - count == TIMEOUT-1 with neither of the above: timeout_err pulses.
//    - trans_done and timeout in the same cycle: trans_done wins, no timeout_err.
//  - RELEASE: one turnaround cycle; grant deasserted, mux outputs 0, rr_ptr = win+1 mod N. New grant earliest 2 cycles after release.
//  - Mux (combinational from registered win_idx/sel_idx, enabled only in BUSY):
//    - s_*[sel_idx] = m_*[win_idx]
//    - m_rx_data/m_slave_valid/m_slave_ready[win_idx] = s_*[sel_idx]
//    - all unselected outputs 0.
//  - Fairness: with all masters requesting continuously, each is granted once per NUM_MASTERS transactions.
//  - Counter width: $clog2(TIMEOUT); no wrap beyond TIMEOUT-1.
// STRUCTURE
//  - bus_defs.vh: FSM state encodings (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2), default widths.
//  - Sub-module rr_arbiter_core: request vector + rr_ptr -> one-hot winner and index, combinational.
//  - Mux and FSM stay in this module.
// TESTING
//  1. Reset, N=2,M=3; m_request=01, sel0=2 -> m_grant=01 next cycle, bus_busy=1, s_rx_data[2] follows m_tx_data[0], s_rx_data[0..1]=0.
//  2. m_request=11 held, trans_done every 5 cycles -> grants alternate 01,10,01,10, with a RELEASE cycle between grants.
//  3. m_request=10, sel1=3 (M=3) -> m_error=10 for one cycle, no grant; rr_ptr advances to 0.
//  4. Grant held, no trans_done, TIMEOUT=8 -> timeout_err pulses after 8 BUSY cycles, grant drops, bus idle.
//  5. trans_done on the same cycle as count==TIMEOUT-1 -> release with timeout_err=0.
//  6. sys_rst low mid-BUSY -> all outputs 0 asynchronously; after release of reset, m_request=01 is granted with rr_ptr=0.

Source files
------------

// File: rtl/bus_interconnect_nxm_pkg.sv
// ---------------------------------------------------------------------------
// bus_interconnect_nxm_pkg
//   Shared state encoding and index helper for the N x M bus interconnect.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_interconnect_nxm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } bus_state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_interconnect_nxm_rr_arbiter_core.sv
// ---------------------------------------------------------------------------
// rr_arbiter_core
//   Combinational round-robin pick: first request at or above the pointer.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_core #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic                   o_any_req,
    output logic [NUM_MASTERS-1:0] o_win_oh,
    output logic [IDX_W-1:0]       o_win_idx
);

    logic w_found;
    int   w_k;

    always_comb begin
        o_any_req = |i_req;
        o_win_oh  = '0;
        o_win_idx = '0;
        w_found   = 1'b0;
        w_k       = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_k = int'(i_rr_ptr) + i;
            if (w_k >= NUM_MASTERS) begin
                w_k = w_k - NUM_MASTERS;
            end
            if (!w_found && i_req[w_k]) begin
                w_found       = 1'b1;
                o_win_oh[w_k] = 1'b1;
                o_win_idx     = IDX_W'(w_k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bus_interconnect_nxm.sv
// ---------------------------------------------------------------------------
// bus_interconnect_nxm
//   N-master x M-slave interconnect: round-robin grant FSM and steered mux.
//   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_interconnect_nxm
    import bus_interconnect_nxm_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT     = 256
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [NUM_MASTERS-1:0]       m_request,
    input  logic [NUM_MASTERS*SEL_W-1:0] m_slave_sel,
    input  logic                         trans_done,
    output logic [NUM_MASTERS-1:0]       m_grant,
    output logic [NUM_MASTERS-1:0]       m_error,
    output logic                         timeout_err,
    output logic                         arbiter_busy,
    output logic                         bus_busy,
    input  logic [NUM_MASTERS-1:0]       m_master_valid,
    input  logic [NUM_MASTERS-1:0]       m_master_ready,
    input  logic [NUM_MASTERS-1:0]       m_tx_address,
    input  logic [NUM_MASTERS-1:0]       m_tx_data,
    input  logic [NUM_MASTERS-1:0]       m_tx_burst_num,
    input  logic [NUM_MASTERS-1:0]       m_write_en,
    input  logic [NUM_MASTERS-1:0]       m_read_en,
    output logic [NUM_MASTERS-1:0]       m_rx_data,
    output logic [NUM_MASTERS-1:0]       m_slave_valid,
    output logic [NUM_MASTERS-1:0]       m_slave_ready,
    output logic [NUM_SLAVES-1:0]        s_master_valid,
    output logic [NUM_SLAVES-1:0]        s_master_ready,
    output logic [NUM_SLAVES-1:0]        s_rx_address,
    output logic [NUM_SLAVES-1:0]        s_rx_data,
    output logic [NUM_SLAVES-1:0]        s_rx_burst_num,
    output logic [NUM_SLAVES-1:0]        s_write_en,
    output logic [NUM_SLAVES-1:0]        s_read_en,
    input  logic [NUM_SLAVES-1:0]        s_tx_data,
    input  logic [NUM_SLAVES-1:0]        s_slave_valid,
    input  logic [NUM_SLAVES-1:0]        s_slave_ready
);

    localparam int                 c_IDX_W    = $clog2(NUM_MASTERS);
    localparam int                 c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    bus_state_e                r_state;
    logic [c_IDX_W-1:0]        r_rr_ptr;
    logic [c_IDX_W-1:0]        r_win_idx;
    logic [NUM_SLAVES-1:0]     r_sel_oh;
    logic [NUM_MASTERS-1:0]    r_grant;
    logic [NUM_MASTERS-1:0]    r_error;
    logic                      r_timeout;
    logic [c_CNT_W-1:0]        r_count;

    logic                      w_any_req;
    logic [NUM_MASTERS-1:0]    w_win_oh;
    logic [c_IDX_W-1:0]        w_win_idx;
    logic [SEL_W-1:0]          w_sel;
    logic                      w_sel_ok;
    logic [NUM_SLAVES-1:0]     w_sel_oh;
    logic                      w_owner_req;

    rr_arbiter_core #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_arb (
        .i_req     (m_request),
        .i_rr_ptr  (r_rr_ptr),
        .o_any_req (w_any_req),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx)
    );

    // Slave select of whichever master the arbiter is currently picking.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_win_oh[i]) begin
                w_sel = m_slave_sel[i*SEL_W +: SEL_W];
            end
        end
    end

    always_comb begin
        w_sel_oh = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            w_sel_oh[s] = (32'(w_sel) == 32'(s));
        end
    end

    assign w_sel_ok    = (32'(w_sel) < 32'(NUM_SLAVES));
    assign w_owner_req = |(m_request & r_grant);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_win_idx <= '0;
            r_sel_oh  <= '0;
            r_grant   <= '0;
            r_error   <= '0;
            r_timeout <= 1'b0;
            r_count   <= '0;
        end else begin
            r_error   <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_win_idx <= w_win_idx;
                        if (w_sel_ok) begin
                            r_state  <= ST_BUSY;
                            r_grant  <= w_win_oh;
                            r_sel_oh <= w_sel_oh;
                            r_count  <= '0;
                        end else begin
                            // Refused request still consumes its round-robin turn.
                            r_error  <= w_win_oh;
                            r_rr_ptr <= c_IDX_W'(wrap_inc(32'(w_win_idx), NUM_MASTERS));
                        end
                    end
                end
                ST_BUSY: begin
                    if (trans_done || !w_owner_req) begin
                        r_state <= ST_RELEASE;
                        r_grant <= '0;
                    end else if (r_count == c_CNT_LAST) begin
                        r_state   <= ST_RELEASE;
                        r_grant   <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    r_state  <= ST_IDLE;
                    r_sel_oh <= '0;
                    r_rr_ptr <= c_IDX_W'(wrap_inc(32'(r_win_idx), NUM_MASTERS));
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign m_grant      = r_grant;
    assign m_error      = r_error;
    assign timeout_err  = r_timeout;
    assign arbiter_busy = (r_state != ST_IDLE);
    assign bus_busy     = (r_state == ST_BUSY);

    // Path enables are one-hot and zero outside BUSY, so AND-OR steering suffices.
    logic [NUM_MASTERS-1:0] w_m_en;
    logic [NUM_SLAVES-1:0]  w_s_en;

    assign w_m_en = bus_busy ? r_grant  : '0;
    assign w_s_en = bus_busy ? r_sel_oh : '0;

    assign s_master_valid = w_s_en & {NUM_SLAVES{|(m_master_valid & w_m_en)}};
    assign s_master_ready = w_s_en & {NUM_SLAVES{|(m_master_ready & w_m_en)}};
    assign s_rx_address   = w_s_en & {NUM_SLAVES{|(m_tx_address   & w_m_en)}};
    assign s_rx_data      = w_s_en & {NUM_SLAVES{|(m_tx_data      & w_m_en)}};
    assign s_rx_burst_num = w_s_en & {NUM_SLAVES{|(m_tx_burst_num & w_m_en)}};
    assign s_write_en     = w_s_en & {NUM_SLAVES{|(m_write_en     & w_m_en)}};
    assign s_read_en      = w_s_en & {NUM_SLAVES{|(m_read_en      & w_m_en)}};

    assign m_rx_data      = w_m_en & {NUM_MASTERS{|(s_tx_data     & w_s_en)}};
    assign m_slave_valid  = w_m_en & {NUM_MASTERS{|(s_slave_valid & w_s_en)}};
    assign m_slave_ready  = w_m_en & {NUM_MASTERS{|(s_slave_ready & w_s_en)}};

endmodule

`default_nettype wire
